// File: rtl/writeback_unit_if.sv
// Writeback unit bus bundle.
// Groups the upstream instruction handshake, the data-memory load response,
// the register-file write port, the forwarding tap and the sticky error flags.
//   slave  : the writeback unit (consumes in_*/mem_*, drives in_ready/rf_*/fwd_*/err_*)
//   master : the environment (upstream stage, memory, register file)
interface writeback_unit_if #(
  parameter int unsigned GPR_WIDTH     = 32,
  parameter int unsigned REG_IDX_WIDTH = 5
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [REG_IDX_WIDTH-1:0] in_rd;
  logic [2:0]               in_wb_src;
  logic [GPR_WIDTH-1:0]     in_alu_result;
  logic [GPR_WIDTH-1:0]     in_pc_link;
  logic [15:0]              in_imm16;
  logic [GPR_WIDTH-1:0]     in_rd_old;
  logic                     mem_rvalid;
  logic [GPR_WIDTH-1:0]     mem_rdata;
  logic                     rf_en;
  logic [REG_IDX_WIDTH-1:0] rf_rd;
  logic [GPR_WIDTH-1:0]     rf_data;
  logic                     fwd_valid;
  logic [REG_IDX_WIDTH-1:0] fwd_rd;
  logic [GPR_WIDTH-1:0]     fwd_data;
  logic                     err_timeout;
  logic                     err_rd;

  modport slave (
    input  in_valid, in_rd, in_wb_src, in_alu_result, in_pc_link, in_imm16, in_rd_old,
    input  mem_rvalid, mem_rdata,
    output in_ready, rf_en, rf_rd, rf_data, fwd_valid, fwd_rd, fwd_data,
    output err_timeout, err_rd
  );

  modport master (
    output in_valid, in_rd, in_wb_src, in_alu_result, in_pc_link, in_imm16, in_rd_old,
    output mem_rvalid, mem_rdata,
    input  in_ready, rf_en, rf_rd, rf_data, fwd_valid, fwd_rd, fwd_data,
    input  err_timeout, err_rd
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: final pipeline stage driving the GPR file write port.
// Selects the result source (ALU, LOAD, LINK, LCL, LCH), waits for load
// responses with a timeout, merges lcl/lch half-words with the old register
// value (bypassing the in-flight write) and exposes a forwarding tap.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-low reset
//   wb  : writeback_unit_if.slave bundle (in_* handshake, mem_* response,
//         rf_* write port, fwd_* tap, err_* sticky flags)
module writeback_unit #(
  parameter int unsigned GPR_WIDTH     = 32,
  parameter int unsigned REG_IDX_WIDTH = 5,
  parameter int unsigned NUM_REGS      = 16,
  parameter int unsigned MEM_TIMEOUT   = 15
) (
  input  logic                clk,
  input  logic                rst,
  writeback_unit_if.slave     wb
);

  localparam int unsigned CNT_W = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_MEM
  } state_t;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_ALU  = 3'd1,
    SRC_LOAD = 3'd2,
    SRC_LINK = 3'd3,
    SRC_LCL  = 3'd4,
    SRC_LCH  = 3'd5
  } wb_src_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [REG_IDX_WIDTH-1:0] ld_rd_q, ld_rd_d;
  logic                     ld_ok_q, ld_ok_d;
  logic                     rf_en_q, rf_en_d;
  logic [REG_IDX_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [GPR_WIDTH-1:0]     rf_data_q, rf_data_d;
  logic                     err_timeout_q, err_timeout_d;
  logic                     err_rd_q, err_rd_d;

  logic                     rd_legal;
  logic [GPR_WIDTH-1:0]     old_val;
  wb_src_t                  src;

  assign src      = wb_src_t'(wb.in_wb_src);
  assign rd_legal = ({1'b0, wb.in_rd} < (REG_IDX_WIDTH + 1)'(NUM_REGS));

  // The register file has not yet absorbed the write on its port this cycle,
  // so in_rd_old is stale for a back-to-back lcl/lch to the same register.
  assign old_val = (rf_en_q && (rf_rd_q == wb.in_rd)) ? rf_data_q : wb.in_rd_old;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ld_rd_d       = ld_rd_q;
    ld_ok_d       = ld_ok_q;
    rf_en_d       = 1'b0;
    rf_rd_d       = rf_rd_q;
    rf_data_d     = rf_data_q;
    err_timeout_d = err_timeout_q;
    err_rd_d      = err_rd_q;

    unique case (state_q)
      IDLE: begin
        if (wb.in_valid) begin
          case (src)
            SRC_ALU, SRC_LINK, SRC_LCL, SRC_LCH: begin
              if (rd_legal) begin
                rf_en_d = 1'b1;
                rf_rd_d = wb.in_rd;
                case (src)
                  SRC_ALU:  rf_data_d = wb.in_alu_result;
                  SRC_LINK: rf_data_d = wb.in_pc_link;
                  SRC_LCL:  rf_data_d = {old_val[GPR_WIDTH-1:16], wb.in_imm16};
                  default:  rf_data_d = {wb.in_imm16, old_val[15:0]};
                endcase
              end else begin
                err_rd_d = 1'b1;
              end
            end
            SRC_LOAD: begin
              // An illegal load index still waits out its response; only the
              // write is dropped.
              state_d = WAIT_MEM;
              cnt_d   = '0;
              ld_rd_d = wb.in_rd;
              ld_ok_d = rd_legal;
              if (!rd_legal) err_rd_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      WAIT_MEM: begin
        if (wb.mem_rvalid) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (ld_ok_q) begin
            rf_en_d   = 1'b1;
            rf_rd_d   = ld_rd_q;
            rf_data_d = wb.mem_rdata;
          end
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          // Counter would reach MEM_TIMEOUT on this edge: give up.
          state_d       = IDLE;
          cnt_d         = '0;
          err_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ld_rd_q       <= '0;
      ld_ok_q       <= 1'b0;
      rf_en_q       <= 1'b0;
      rf_rd_q       <= '0;
      rf_data_q     <= '0;
      err_timeout_q <= 1'b0;
      err_rd_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ld_rd_q       <= ld_rd_d;
      ld_ok_q       <= ld_ok_d;
      rf_en_q       <= rf_en_d;
      rf_rd_q       <= rf_rd_d;
      rf_data_q     <= rf_data_d;
      err_timeout_q <= err_timeout_d;
      err_rd_q      <= err_rd_d;
    end
  end

  assign wb.in_ready    = (state_q == IDLE);
  assign wb.rf_en       = rf_en_q;
  assign wb.rf_rd       = rf_rd_q;
  assign wb.rf_data     = rf_data_q;
  assign wb.fwd_valid   = rf_en_q;
  assign wb.fwd_rd      = rf_rd_q;
  assign wb.fwd_data    = rf_data_q;
  assign wb.err_timeout = err_timeout_q;
  assign wb.err_rd      = err_rd_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: expected register-file writes are
// queued when the producing stimulus is driven and popped by a monitor on
// every rf_en; directed checks cover handshake, timeout and error flags.
module tb_writeback_unit;

  localparam int unsigned GPR_WIDTH     = 32;
  localparam int unsigned REG_IDX_WIDTH = 5;
  localparam int unsigned NUM_REGS      = 16;
  localparam int unsigned MEM_TIMEOUT   = 15;

  localparam logic [2:0] S_NONE = 3'd0, S_ALU = 3'd1, S_LOAD = 3'd2,
                         S_LINK = 3'd3, S_LCL = 3'd4, S_LCH = 3'd5, S_BAD6 = 3'd6;

  typedef struct {
    logic [REG_IDX_WIDTH-1:0] rd;
    logic [GPR_WIDTH-1:0]     data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  wr_t  sb[$];

  always #5 clk = ~clk;

  writeback_unit_if #(.GPR_WIDTH(GPR_WIDTH), .REG_IDX_WIDTH(REG_IDX_WIDTH)) wb ();

  writeback_unit #(
    .GPR_WIDTH    (GPR_WIDTH),
    .REG_IDX_WIDTH(REG_IDX_WIDTH),
    .NUM_REGS     (NUM_REGS),
    .MEM_TIMEOUT  (MEM_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb (wb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [REG_IDX_WIDTH-1:0] rd, input logic [GPR_WIDTH-1:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  // Presents one instruction for exactly one accepting edge.
  task automatic drive(input logic [2:0] src, input logic [REG_IDX_WIDTH-1:0] rd,
                       input logic [31:0] alu, input logic [31:0] link,
                       input logic [15:0] imm, input logic [31:0] old);
    wb.in_valid      = 1'b1;
    wb.in_wb_src     = src;
    wb.in_rd         = rd;
    wb.in_alu_result = alu;
    wb.in_pc_link    = link;
    wb.in_imm16      = imm;
    wb.in_rd_old     = old;
    step();
    wb.in_valid      = 1'b0;
  endtask

  // Monitor: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && wb.rf_en) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {31'd0, wb.rf_en}, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_rd",     {27'd0, wb.rf_rd},  {27'd0, e.rd});
        check("wr_data",   wb.rf_data,         e.data);
        check("fwd_valid", {31'd0, wb.fwd_valid}, 32'd1);
        check("fwd_rd",    {27'd0, wb.fwd_rd}, {27'd0, e.rd});
        check("fwd_data",  wb.fwd_data,        e.data);
      end
    end
  end

  initial begin
    wb.in_valid      = 1'b0;
    wb.in_wb_src     = '0;
    wb.in_rd         = '0;
    wb.in_alu_result = '0;
    wb.in_pc_link    = '0;
    wb.in_imm16      = '0;
    wb.in_rd_old     = '0;
    wb.mem_rvalid    = 1'b0;
    wb.mem_rdata     = '0;

    // Reset
    rst = 1'b0;
    step();
    step();
    check("rst_rf_en",   {31'd0, wb.rf_en}, 32'd0);
    check("rst_rf_rd",   {27'd0, wb.rf_rd}, 32'd0);
    check("rst_rf_data", wb.rf_data, 32'd0);
    check("rst_err_to",  {31'd0, wb.err_timeout}, 32'd0);
    check("rst_err_rd",  {31'd0, wb.err_rd}, 32'd0);
    check("rst_ready",   {31'd0, wb.in_ready}, 32'd1);
    rst = 1'b1;
    step();

    // ALU write, then rf_en drops
    push(5'd3, 32'hDEADBEEF);
    drive(S_ALU, 5'd3, 32'hDEADBEEF, 32'h0, 16'h0, 32'h0);
    check("alu_en", {31'd0, wb.rf_en}, 32'd1);
    step();
    check("alu_en_drop", {31'd0, wb.rf_en}, 32'd0);
    check("alu_hold_data", wb.rf_data, 32'hDEADBEEF);

    // LCL then LCH back-to-back with stale old value (bypass)
    push(5'd5, 32'hAAAA1234);
    drive(S_LCL, 5'd5, 32'h0, 32'h0, 16'h1234, 32'hAAAA5555);
    push(5'd5, 32'hBEEF1234);
    drive(S_LCH, 5'd5, 32'h0, 32'h0, 16'hBEEF, 32'hAAAA5555);
    // LCH not preceded by a matching write uses in_rd_old
    step();
    push(5'd6, 32'h77770000 | 32'h0000_1111);
    drive(S_LCH, 5'd6, 32'h0, 32'h0, 16'h7777, 32'h55551111);
    // LINK to highest legal index, then a none-source accept
    push(5'd15, 32'h00001004);
    drive(S_LINK, 5'd15, 32'hFFFFFFFF, 32'h00001004, 16'h0, 32'h0);
    drive(S_BAD6, 5'd4, 32'h12121212, 32'h0, 16'h0, 32'h0);
    check("none_no_write", {31'd0, wb.rf_en}, 32'd0);
    drive(S_NONE, 5'd4, 32'h34343434, 32'h0, 16'h0, 32'h0);
    check("none0_no_write", {31'd0, wb.rf_en}, 32'd0);
    check("none_err_rd", {31'd0, wb.err_rd}, 32'd0);

    // Load with response on the third wait cycle
    drive(S_LOAD, 5'd7, 32'h0, 32'h0, 16'h0, 32'h0);
    check("ld_wait_ready", {31'd0, wb.in_ready}, 32'd0);
    step();
    step();
    check("ld_wait_ready2", {31'd0, wb.in_ready}, 32'd0);
    check("ld_wait_no_wr", {31'd0, wb.rf_en}, 32'd0);
    wb.mem_rvalid = 1'b1;
    wb.mem_rdata  = 32'h0000CAFE;
    push(5'd7, 32'h0000CAFE);
    step();
    wb.mem_rvalid = 1'b0;
    check("ld_done_en", {31'd0, wb.rf_en}, 32'd1);
    check("ld_done_ready", {31'd0, wb.in_ready}, 32'd1);
    step();

    // mem_rvalid in IDLE is ignored
    wb.mem_rvalid = 1'b1;
    wb.mem_rdata  = 32'h0BADF00D;
    step();
    wb.mem_rvalid = 1'b0;
    check("idle_rvalid_ignored", {31'd0, wb.rf_en}, 32'd0);

    // Load timeout: still waiting after MEM_TIMEOUT-1 cycles, gives up on the next
    drive(S_LOAD, 5'd2, 32'h0, 32'h0, 16'h0, 32'h0);
    for (int i = 0; i < int'(MEM_TIMEOUT) - 1; i++) step();
    check("to_still_wait", {31'd0, wb.in_ready}, 32'd0);
    check("to_not_yet", {31'd0, wb.err_timeout}, 32'd0);
    step();
    check("to_err", {31'd0, wb.err_timeout}, 32'd1);
    check("to_ready", {31'd0, wb.in_ready}, 32'd1);
    check("to_no_write", {31'd0, wb.rf_en}, 32'd0);
    wb.mem_rvalid = 1'b1;
    wb.mem_rdata  = 32'h11111111;
    step();
    wb.mem_rvalid = 1'b0;
    check("late_rvalid_ignored", {31'd0, wb.rf_en}, 32'd0);

    // Illegal destination index
    drive(S_ALU, 5'd17, 32'hCCCCCCCC, 32'h0, 16'h0, 32'h0);
    check("ill_no_write", {31'd0, wb.rf_en}, 32'd0);
    check("ill_err_rd", {31'd0, wb.err_rd}, 32'd1);
    drive(S_ALU, 5'd16, 32'hDDDDDDDD, 32'h0, 16'h0, 32'h0);
    check("ill16_no_write", {31'd0, wb.rf_en}, 32'd0);
    push(5'd1, 32'h12345678);
    drive(S_ALU, 5'd1, 32'h12345678, 32'h0, 16'h0, 32'h0);
    step();
    check("sticky_to", {31'd0, wb.err_timeout}, 32'd1);
    check("sticky_rd", {31'd0, wb.err_rd}, 32'd1);

    // Reset while waiting for a load
    drive(S_LOAD, 5'd9, 32'h0, 32'h0, 16'h0, 32'h0);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_ready", {31'd0, wb.in_ready}, 32'd1);
    check("mid_rst_err_to", {31'd0, wb.err_timeout}, 32'd0);
    check("mid_rst_err_rd", {31'd0, wb.err_rd}, 32'd0);
    check("mid_rst_rf_rd", {27'd0, wb.rf_rd}, 32'd0);
    wb.mem_rvalid = 1'b1;
    wb.mem_rdata  = 32'h99999999;
    step();
    wb.mem_rvalid = 1'b0;
    check("mid_rst_no_write", {31'd0, wb.rf_en}, 32'd0);
    check("mid_rst_rf_data", wb.rf_data, 32'd0);
    check("mid_rst_ready2", {31'd0, wb.in_ready}, 32'd1);

    step();
    step();
    check("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
